ack_frame_packer: RTL and testbench

//  Downstream consumer of the 16-bit x 64 ACK FIFO. Pops ACK words, gathers up to MAX_WORDS

---
 rtl/ack_pkg.sv | 16 +
 rtl/ack_pack_buf.sv | 64 ++++++
 rtl/ack_frame_packer.sv | 143 ++++++++++++++
 tb/tb_ack_frame_packer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ack_pkg.sv
// Shared ACK-path definitions: packer FSM encoding, header tag, ACK word width.
// Also used by the ACK FIFO wrapper and the uplink serializer.
package ack_pkg;

  localparam int ACK_W = 16;
  localparam logic [7:0] ACK_HDR_TAG = 8'hAC;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4
  } ack_state_e;

endpackage

// File: rtl/ack_pack_buf.sv
// Payload staging buffer for the ACK frame packer.
// Words leave in arrival order; count tracks words not yet read.
module ack_pack_buf #(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        count
);

  localparam int PTR_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_WORDS - 1);

  logic [DATA_W-1:0] mem_q [MAX_WORDS];
  logic [DATA_W-1:0] mem_d [MAX_WORDS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + 8'(wr_en) - 8'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MAX_WORDS; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/ack_frame_packer.sv
// Drains the ACK FIFO into batches and emits header/payload/XOR-checksum
// frames on a valid/ready uplink stream.
module ack_frame_packer
  import ack_pkg::*;
#(
  parameter int         DATA_W    = ACK_W,
  parameter int         MAX_WORDS = 8,
  parameter int         RD_LAT    = 1,
  parameter logic [7:0] HDR_TAG   = ACK_HDR_TAG,
  parameter int         TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FIFO_EMPTY,
  input  logic              FIFO_AEMPTY,
  input  logic [DATA_W-1:0] FIFO_Q,
  output logic              FIFO_RE,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic [15:0]       FRAME_CNT
);

  localparam logic [8:0] MAX9 = 9'(MAX_WORDS);
  localparam logic [7:0] TMO8 = 8'(TIMEOUT);

  ack_state_e        state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [1:0]        pipe_q, pipe_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              buf_wr, buf_rd, buf_clr;
  logic [DATA_W-1:0] buf_rdata;
  logic [7:0]        buf_cnt;
  logic [1:0]        inflight;
  logic [8:0]        pend;
  logic [8:0]        cnt_eff;
  logic [DATA_W-1:0] hdr_word;

  ack_pack_buf #(
    .DATA_W   (DATA_W),
    .MAX_WORDS(MAX_WORDS)
  ) u_buf (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (buf_clr),
    .wr_en  (buf_wr),
    .wr_data(FIFO_Q),
    .rd_en  (buf_rd),
    .rd_data(buf_rdata),
    .count  (buf_cnt)
  );

  // pipe_q tracks outstanding pops; the oldest lands RD_LAT cycles after RE
  assign buf_wr   = pipe_q[RD_LAT-1];
  assign inflight = (RD_LAT == 2)
                  ? {1'b0, pipe_q[0]} + {1'b0, pipe_q[1]}
                  : {1'b0, pipe_q[0]};
  assign pend     = 9'(inflight) + {1'b0, buf_cnt};
  assign cnt_eff  = {1'b0, buf_cnt} + 9'(buf_wr);
  assign hdr_word = DATA_W'({HDR_TAG, buf_cnt});
  assign pipe_d   = {pipe_q[0], FIFO_RE};

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    FIFO_RE     = 1'b0;
    OUT_VALID   = 1'b0;
    OUT_DATA    = '0;
    OUT_LAST    = 1'b0;
    buf_rd      = 1'b0;
    buf_clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!FIFO_EMPTY && FIFO_AEMPTY)
          timer_d = (timer_q == TMO8) ? timer_q : timer_q + 8'd1;
        if (!FIFO_EMPTY && (!FIFO_AEMPTY || timer_q == TMO8))
          state_d = ST_FILL;
      end
      ST_FILL: begin
        FIFO_RE = !FIFO_EMPTY && (pend < MAX9)
               && (!FIFO_AEMPTY || inflight == 2'd0);
        // a word landing this cycle counts as buffered already
        if (inflight == {1'b0, buf_wr} && cnt_eff != 9'd0
            && (cnt_eff == MAX9 || FIFO_EMPTY))
          state_d = ST_HDR;
      end
      ST_HDR: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = hdr_word;
        if (OUT_READY) begin
          csum_d  = hdr_word;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = buf_rdata;
        if (OUT_READY) begin
          csum_d = csum_q ^ buf_rdata;
          buf_rd = 1'b1;
          if (buf_cnt == 8'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = csum_q;
        OUT_LAST  = 1'b1;
        if (OUT_READY) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          buf_clr     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pipe_q      <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pipe_q      <= pipe_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_ack_frame_packer.sv
// Self-checking bench for ack_frame_packer: FIFO model, stream monitor,
// and a chunking reference model of the expected frames.
module tb_ack_frame_packer;

  localparam int DW   = 16;
  localparam int MAXW = 8;
  localparam int RDL  = 2;
  localparam int TMO  = 255;
  localparam int MEMN = 4096;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FIFO_EMPTY, FIFO_AEMPTY, FIFO_RE;
  logic [15:0] FIFO_Q;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID, OUT_READY, OUT_LAST, BUSY;
  logic [15:0] FRAME_CNT;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ack_frame_packer #(
    .DATA_W   (DW),
    .MAX_WORDS(MAXW),
    .RD_LAT   (RDL),
    .HDR_TAG  (8'hAC),
    .TIMEOUT  (TMO)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_AEMPTY(FIFO_AEMPTY),
    .FIFO_Q     (FIFO_Q),
    .FIFO_RE    (FIFO_RE),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_LAST   (OUT_LAST),
    .BUSY       (BUSY),
    .FRAME_CNT  (FRAME_CNT)
  );

  // FIFO model with RDL-cycle read latency
  logic [15:0] mem [MEMN];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflows = 0;
  logic [15:0] q_s0 = '0, q_s1 = '0;

  assign FIFO_EMPTY  = (wr_ptr == rd_ptr);
  assign FIFO_AEMPTY = ((wr_ptr - rd_ptr) <= 3);
  assign FIFO_Q      = (RDL == 2) ? q_s1 : q_s0;

  always @(posedge CLK) begin
    if (FIFO_RE) begin
      if (rd_ptr == wr_ptr) underflows <= underflows + 1;
      else begin
        q_s0   <= mem[rd_ptr % MEMN];
        rd_ptr <= rd_ptr + 1;
      end
    end
    q_s1 <= q_s0;
  end

  // stream monitor
  logic [16:0] rx[$];
  logic [16:0] exp_q[$];
  int   re_bad = 0;
  int   stab_bad = 0;
  logic stalled = 1'b0;
  logic [16:0] held = '0;

  always @(posedge CLK) begin
    if (OUT_VALID && FIFO_RE) re_bad++;
    if (stalled && !RESET && ({OUT_LAST, OUT_DATA} !== held)) stab_bad++;
    if (OUT_VALID && OUT_READY && !RESET) rx.push_back({OUT_LAST, OUT_DATA});
    stalled = OUT_VALID && !OUT_READY && !RESET;
    held    = {OUT_LAST, OUT_DATA};
  end

  // ready driver: 0 always, 1 pattern 1-0-0-1, 2 random
  int rdy_mode = 0;
  int cyc = 0;
  always @(negedge CLK) begin
    cyc++;
    case (rdy_mode)
      0: OUT_READY = 1'b1;
      1: case (cyc % 4)
           0: OUT_READY = 1'b1;
           1: OUT_READY = 1'b0;
           2: OUT_READY = 1'b0;
           default: OUT_READY = 1'b1;
         endcase
      default: OUT_READY = ($urandom_range(0, 3) != 0);
    endcase
  end

  // reference: words go out in chunks of MAXW, remainder as one short frame
  function automatic void add_frames(input logic [15:0] w[$]);
    int idx = 0;
    while (idx < w.size()) begin
      int n = (w.size() - idx > MAXW) ? MAXW : w.size() - idx;
      logic [15:0] hdr = {8'hAC, 8'(n)};
      logic [15:0] cs = hdr;
      exp_q.push_back({1'b0, hdr});
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({1'b0, w[idx + k]});
        cs ^= w[idx + k];
      end
      exp_q.push_back({1'b1, cs});
      idx += n;
    end
  endfunction

  task automatic push_words(input logic [15:0] w[$]);
    foreach (w[i]) begin
      mem[wr_ptr % MEMN] = w[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  function automatic int count_lasts();
    int c = 0;
    foreach (rx[i]) if (rx[i][16]) c++;
    return c;
  endfunction

  task automatic wait_lasts(input int n, input int budget, input string name);
    int t = 0;
    while (count_lasts() < n && t < budget) begin
      @(negedge CLK);
      t++;
    end
    vectors++;
    if (count_lasts() < n) begin
      miscompares++;
      $display("FAIL %s_timeout: frames=%0d required=%0d", name, count_lasts(), n);
    end
  endtask

  task automatic compare_rx(input string name);
    int n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    vectors++;
    if (rx.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_len: got=%0d exp=%0d", name, rx.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (rx[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_word%0d: got=%h exp=%h", name, i, rx[i], exp_q[i]);
      end
    end
    rx.delete();
    exp_q.delete();
  endtask

  task automatic check_rules(input string name);
    vectors++;
    if (underflows !== 0 || re_bad !== 0 || stab_bad !== 0) begin
      miscompares++;
      $display("FAIL %s_rules: underflow=%0d re_busy=%0d unstable=%0d exp=0",
               name, underflows, re_bad, stab_bad);
    end
  endtask

  task automatic check_idle_outs(input string name);
    logic [35:0] got;
    got = {FIFO_RE, OUT_VALID, OUT_LAST, BUSY, OUT_DATA, FRAME_CNT};
    vectors++;
    if (got !== 36'h0) begin
      miscompares++;
      $display("FAIL %s: outputs=%h exp=0", name, got);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    rdy_mode = 0;
    OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle_outs("reset_state");
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_batch();
    logic [15:0] w[$];
    rdy_mode = 0;
    for (int i = 1; i <= 10; i++) w.push_back(16'(i));
    add_frames(w);
    push_words(w);
    wait_lasts(2, 1500, "batch");
    compare_rx("batch");
    vectors++;
    if (FRAME_CNT !== 16'd2) begin
      miscompares++;
      $display("FAIL batch_frame_cnt: got=%0d exp=2", FRAME_CNT);
    end
    check_rules("batch");
  endtask

  task automatic test_timeout();
    logic [15:0] w[$];
    int re_seen = 0;
    w.push_back(16'h1234);
    add_frames(w);
    push_words(w);
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      if (FIFO_RE) re_seen++;
    end
    vectors++;
    if (re_seen !== 0) begin
      miscompares++;
      $display("FAIL timeout_early_re: got=%0d exp=0", re_seen);
    end
    wait_lasts(1, 300, "timeout");
    vectors++;
    if (rx.size() == 3 && rx[2] !== {1'b1, 16'hBE35}) begin
      miscompares++;
      $display("FAIL timeout_csum: got=%h exp=1be35", rx[2]);
    end
    compare_rx("timeout");
  endtask

  task automatic test_stall();
    logic [15:0] w[$];
    rdy_mode = 1;
    for (int i = 1; i <= 10; i++) w.push_back(16'(i));
    add_frames(w);
    push_words(w);
    wait_lasts(2, 3000, "stall");
    compare_rx("stall");
    check_rules("stall");
    rdy_mode = 0;
  endtask

  task automatic test_drain();
    logic [15:0] w[$];
    for (int n = 4; n <= 7; n++) begin
      w.delete();
      rdy_mode = 2;
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      add_frames(w);
      push_words(w);
      wait_lasts(1, 1000, "drain");
      compare_rx("drain");
    end
    check_rules("drain");
    rdy_mode = 0;
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 20);
      w.delete();
      rdy_mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      add_frames(w);
      push_words(w);
      wait_lasts((n + MAXW - 1) / MAXW, 3000, "random");
      compare_rx("random");
    end
    check_rules("random");
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[$];
    int t = 0;
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) w.push_back(16'h5000 + 16'(i));
    push_words(w);
    while (rx.size() < 3 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    vectors++;
    if (!(rx.size() >= 3 && BUSY)) begin
      miscompares++;
      $display("FAIL reset_mid_reach_pay: rx=%0d busy=%b exp=rx>=3,busy=1", rx.size(), BUSY);
    end
    RESET = 1'b1;
    @(negedge CLK);
    check_idle_outs("reset_mid_outputs");
    RESET = 1'b0;
    rx.delete();
    exp_q.delete();
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
    add_frames(w);
    push_words(w);
    wait_lasts(1, 1000, "reset_mid");
    compare_rx("reset_mid");
  endtask

  task automatic test_wrap();
    logic [15:0] w[$];
    @(negedge CLK);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.frame_cnt_q;
    @(negedge CLK);
    vectors++;
    if (FRAME_CNT !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preset: got=%h exp=ffff", FRAME_CNT);
    end
    for (int i = 0; i < 4; i++) w.push_back(16'hA0A0 ^ 16'(i));
    add_frames(w);
    push_words(w);
    wait_lasts(1, 1000, "wrap");
    compare_rx("wrap");
    @(negedge CLK);
    vectors++;
    if (FRAME_CNT !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_cnt: got=%h exp=0000", FRAME_CNT);
    end
  endtask

  initial begin
    RESET = 1'b1;
    OUT_READY = 1'b1;
    test_reset();
    test_batch();
    test_timeout();
    test_stall();
    test_drain();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
